// File: rtl/adc_axis_packer_if.sv
// AXI4-Stream master channel carrying
// packed ADC samples.
interface adc_axis_packer_if #(
  parameter int DW = 32
);
  logic          m00_axis_tvalid;
  logic          m00_axis_tready;
  logic          m00_axis_tlast;
  logic [DW-1:0] m00_axis_tdata;
  logic [DW/8-1:0] m00_axis_tstrb;

  modport master (
    output m00_axis_tvalid,
    output m00_axis_tlast,
    output m00_axis_tdata,
    output m00_axis_tstrb,
    input  m00_axis_tready
  );

  modport slave (
    input  m00_axis_tvalid,
    input  m00_axis_tlast,
    input  m00_axis_tdata,
    input  m00_axis_tstrb,
    output m00_axis_tready
  );
endinterface

// File: rtl/adc_axis_packer.sv
// ADC sample scaler and AXIS frame packer
// behind a first-word-fall-through FIFO.
module adc_axis_packer #(
  parameter int C_M00_AXIS_TDATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int FRAME_LEN  = 256
) (
  input  logic        m00_axis_aclk,
  input  logic        m00_axis_aresetn,
  input  logic [7:0]  adc_data,
  input  logic        adc_valid,
  input  logic        enable,
  input  logic [3:0]  shift,
  adc_axis_packer_if.master m00_axis,
  output logic        overflow,
  output logic [15:0] drop_count
);

  localparam int DW = C_M00_AXIS_TDATA_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int FW =
    (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  logic [DW:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [FW-1:0] r_frame;
  logic          r_overflow;
  logic [15:0]   r_drop_cnt;

  logic          w_valid;
  logic          w_pop;
  logic          w_req;
  logic          w_push;
  logic          w_drop;
  logic          w_full;
  logic          w_last;
  logic signed [7:0]    w_s8;
  logic signed [DW-1:0] w_ext;
  logic [DW-1:0] w_conv;
  logic [DW:0]   w_head;

  // Offset binary to two's complement,
  // widened with sign, then scaled.
  assign w_s8   = {~adc_data[7], adc_data[6:0]};
  assign w_ext  = DW'(w_s8);
  assign w_conv = w_ext << shift;

  assign w_full  = (r_count == CW'(FIFO_DEPTH));
  assign w_valid = (r_count != '0);
  assign w_pop   = w_valid
                 & m00_axis.m00_axis_tready;
  assign w_req   = adc_valid & enable;
  // A full FIFO still accepts when the head
  // leaves in the same cycle.
  assign w_push  = w_req & (~w_full | w_pop);
  assign w_drop  = w_req & ~w_push;
  assign w_last  =
    (r_frame == FW'(FRAME_LEN - 1));

  // Empty FIFO presents zeros rather than
  // whatever stale entry the pointer hits.
  assign w_head = w_valid ? r_mem[r_rptr] : '0;

  assign m00_axis.m00_axis_tvalid = w_valid;
  assign m00_axis.m00_axis_tlast  = w_head[DW];
  assign m00_axis.m00_axis_tdata  = w_head[DW-1:0];
  assign m00_axis.m00_axis_tstrb  = '1;

  assign overflow   = r_overflow;
  assign drop_count = r_drop_cnt;

  // Sample storage; contents need no reset,
  // the read side is gated by occupancy.
  always_ff @(posedge m00_axis_aclk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {w_last, w_conv};
    end
  end

  // Pointers wrap naturally at FIFO_DEPTH.
  always_ff @(posedge m00_axis_aclk
              or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Occupancy; push with pop leaves it alone.
  always_ff @(posedge m00_axis_aclk
              or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      r_count <= '0;
    end else begin
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Frame position of the next accepted
  // sample; disabling restarts the frame.
  always_ff @(posedge m00_axis_aclk
              or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      r_frame <= '0;
    end else if (!enable) begin
      r_frame <= '0;
    end else if (w_push) begin
      r_frame <= w_last ? '0
                        : r_frame + 1'b1;
    end
  end

  // Sticky overflow and saturating drops.
  always_ff @(posedge m00_axis_aclk
              or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_drop_cnt != 16'hFFFF) begin
        r_drop_cnt <= r_drop_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_adc_axis_packer.sv
// Bench for adc_axis_packer: vector table,
// corner sequences and a queue model.
module tb_adc_axis_packer;

  localparam int DW = 32;
  localparam int DEPTH = 8;
  localparam int FL = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  adc_data = 8'h80;
  logic        adc_valid = 1'b0;
  logic        enable = 1'b0;
  logic [3:0]  shift = 4'd0;
  logic        ov, ov1;
  logic [15:0] dc, dc1;

  adc_axis_packer_if #(.DW(DW)) ax ();
  adc_axis_packer_if #(.DW(DW)) ax1 ();

  assign ax1.m00_axis_tready = 1'b1;

  adc_axis_packer #(
    .C_M00_AXIS_TDATA_WIDTH(DW),
    .FIFO_DEPTH(DEPTH),
    .FRAME_LEN(FL)
  ) dut (
    .m00_axis_aclk(clk),
    .m00_axis_aresetn(rst_n),
    .adc_data(adc_data),
    .adc_valid(adc_valid),
    .enable(enable),
    .shift(shift),
    .m00_axis(ax),
    .overflow(ov),
    .drop_count(dc)
  );

  adc_axis_packer #(
    .C_M00_AXIS_TDATA_WIDTH(DW),
    .FIFO_DEPTH(DEPTH),
    .FRAME_LEN(1)
  ) dut1 (
    .m00_axis_aclk(clk),
    .m00_axis_aresetn(rst_n),
    .adc_data(adc_data),
    .adc_valid(adc_valid),
    .enable(enable),
    .shift(shift),
    .m00_axis(ax1),
    .overflow(ov1),
    .drop_count(dc1)
  );

  typedef struct {
    logic        last;
    logic [31:0] data;
  } ent_t;

  typedef struct {
    logic [7:0]  d;
    int          s;
    logic [31:0] exp;
  } vec_t;

  ent_t q[$];
  int   fi;
  bit   m_ov;
  int   m_dc;
  int   total = 0;
  int   bad = 0;

  function automatic logic [31:0] conv(
    logic [7:0] d, int s);
    int v;
    v = int'(d) - 128;
    return 32'(v * (1 << s));
  endfunction

  task automatic chk(string n,
    logic [31:0] a, logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s actual=%h required=%h",
               n, a, e);
    end
  endtask

  task automatic check_all();
    chk("tvalid", 32'(ax.m00_axis_tvalid),
        32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("tdata", ax.m00_axis_tdata,
          q[0].data);
      chk("tlast", 32'(ax.m00_axis_tlast),
          32'(q[0].last));
    end
    chk("tstrb", 32'(ax.m00_axis_tstrb),
        32'hF);
    chk("overflow", 32'(ov), 32'(m_ov));
    chk("drop_count", 32'(dc), 32'(m_dc));
    if (ax1.m00_axis_tvalid) begin
      chk("fl1_tlast",
          32'(ax1.m00_axis_tlast), 32'd1);
    end
    chk("fl1_drops", 32'(dc1), 32'd0);
  endtask

  task automatic cyc(bit v, logic [7:0] d,
    bit en, int s, bit r);
    bit   pop, acc, drp, lst;
    ent_t ne;
    adc_valid = v;
    adc_data = d;
    enable = en;
    shift = 4'(s);
    ax.m00_axis_tready = r;
    pop = (q.size() > 0) && r;
    acc = v && en && ((q.size() < DEPTH) || pop);
    drp = v && en && !acc;
    if (pop) void'(q.pop_front());
    if (acc) begin
      lst = (fi == FL - 1);
      ne.last = lst;
      ne.data = conv(d, s);
      q.push_back(ne);
      fi = lst ? 0 : fi + 1;
    end
    if (!en) fi = 0;
    if (drp) begin
      m_ov = 1'b1;
      if (m_dc < 65535) m_dc++;
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    adc_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_tvalid",
        32'(ax.m00_axis_tvalid), 32'd0);
    chk("rst_tlast",
        32'(ax.m00_axis_tlast), 32'd0);
    chk("rst_tdata", ax.m00_axis_tdata, 32'd0);
    chk("rst_overflow", 32'(ov), 32'd0);
    chk("rst_drops", 32'(dc), 32'd0);
    q.delete();
    fi = 0;
    m_ov = 1'b0;
    m_dc = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_all();
  endtask

  vec_t vt[8];
  logic [7:0] smp[10];
  logic [31:0] exb[4];
  int got;

  initial begin
    ax.m00_axis_tready = 1'b0;
    vt[0] = '{8'h80, 0,  32'h00000000};
    vt[1] = '{8'hFF, 0,  32'h0000007F};
    vt[2] = '{8'h00, 0,  32'hFFFFFF80};
    vt[3] = '{8'h00, 4,  32'hFFFFF800};
    vt[4] = '{8'h00, 15, 32'hFFC00000};
    vt[5] = '{8'hFF, 15, 32'h003F8000};
    vt[6] = '{8'h81, 0,  32'h00000001};
    vt[7] = '{8'h7F, 1,  32'hFFFFFFFE};
    exb[0] = 32'h0;
    exb[1] = 32'h7F;
    exb[2] = 32'hFFFFFF80;
    exb[3] = 32'h1;

    #3;
    do_reset();

    for (int i = 0; i < 8; i++) begin
      cyc(1, vt[i].d, 1, vt[i].s, 1);
      chk("conv_table", ax.m00_axis_tdata,
          vt[i].exp);
    end
    cyc(0, 8'h0, 1, 0, 1);

    do_reset();
    smp[0] = 8'h80;
    smp[1] = 8'hFF;
    smp[2] = 8'h00;
    smp[3] = 8'h81;
    for (int i = 0; i < 4; i++) begin
      cyc(1, smp[i], 1, 0, 1);
      chk("basic_data", ax.m00_axis_tdata,
          exb[i]);
      chk("basic_last",
          32'(ax.m00_axis_tlast),
          32'(i == 3));
    end
    cyc(0, 8'h0, 1, 0, 1);
    chk("basic_empty",
        32'(ax.m00_axis_tvalid), 32'd0);

    do_reset();
    for (int i = 0; i < 10; i++) begin
      smp[i] = 8'(i * 23 + 5);
      cyc(1, smp[i], 1, 0, 0);
    end
    chk("ovf_flag", 32'(ov), 32'd1);
    chk("ovf_drops", 32'(dc), 32'd2);
    got = 0;
    for (int i = 0; i < 8; i++) begin
      if (ax.m00_axis_tvalid) got++;
      chk("ovf_order", ax.m00_axis_tdata,
          conv(smp[i], 0));
      chk("ovf_last",
          32'(ax.m00_axis_tlast),
          32'(i % 4 == 3));
      cyc(0, 8'h0, 1, 0, 1);
    end
    chk("ovf_count", 32'(got), 32'd8);
    chk("ovf_drained",
        32'(ax.m00_axis_tvalid), 32'd0);
    cyc(1, 8'h90, 1, 0, 1);
    chk("ovf_newframe",
        32'(ax.m00_axis_tlast), 32'd0);
    cyc(0, 8'h0, 1, 0, 1);

    do_reset();
    for (int i = 0; i < 8; i++) begin
      cyc(1, 8'(i + 1), 1, 0, 0);
    end
    cyc(1, 8'h55, 1, 0, 1);
    chk("full_sim_drops", 32'(dc), 32'd0);
    chk("full_sim_ovf", 32'(ov), 32'd0);
    cyc(1, 8'h66, 1, 0, 0);
    chk("full_still8", 32'(dc), 32'd1);
    for (int i = 0; i < 9; i++) begin
      cyc(0, 8'h0, 1, 0, 1);
    end

    do_reset();
    cyc(1, 8'hA0, 1, 0, 1);
    cyc(1, 8'hA1, 1, 0, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 8'hEE, 0, 0, 1);
    end
    cyc(0, 8'h0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 8'(8'hB0 + i), 1, 0, 1);
      chk("en_last",
          32'(ax.m00_axis_tlast),
          32'(i == 3));
    end
    chk("en_drops", 32'(dc), 32'd0);
    cyc(0, 8'h0, 1, 0, 1);

    do_reset();
    for (int i = 0; i < 10; i++) begin
      cyc(1, 8'(i + 64), 1, 0, 0);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(0, 8'h0, 1, 0, 1);
    end
    cyc(1, 8'hC3, 1, 0, 0);
    chk("pre_rst_drops", 32'(dc), 32'd2);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cyc(1, 8'(8'hD0 + i), 1, 2, 1);
      chk("post_rst_last",
          32'(ax.m00_axis_tlast),
          32'(i == 3));
    end
    cyc(0, 8'h0, 1, 0, 1);

    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 3) != 0,
          8'($urandom),
          $urandom_range(0, 7) != 0,
          int'($urandom_range(0, 15)),
          $urandom_range(0, 1) != 0);
    end

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule

// File: doc/adc_axis_packer.md
ADC_AXIS_PACKER -- requirements
Module: adc_axis_packer

Interface
REQ-001 The block SHALL have parameter C_M00_AXIS_TDATA_WIDTH, default 32, width of the output stream data.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 8, a power of two of at least 2, the number of output buffer entries.
REQ-003 The block SHALL have parameter FRAME_LEN, default 256, at least 1, the number of samples per AXIS packet.
REQ-004 The block SHALL have port m00_axis_aclk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port m00_axis_aresetn, input, 1 bit, reset; it is asynchronous and active-low.
REQ-006 The block SHALL have port adc_data, input, 8 bits, the ADC sample in offset binary (0x80 = zero).
REQ-007 The block SHALL have port adc_valid, input, 1 bit, a one-cycle strobe marking a new adc_data.
REQ-008 The block SHALL have port enable, input, 1 bit, the capture enable.
REQ-009 The block SHALL have port shift, input, 4 bits, the left-shift gain (0..15).
REQ-010 The block SHALL have port m00_axis_tready, input, 1 bit, downstream ready.
REQ-011 The block SHALL have port m00_axis_tvalid, output, 1 bit, output data valid.
REQ-012 The block SHALL have port m00_axis_tlast, output, 1 bit, marking the last sample of a frame.
REQ-013 The block SHALL have port m00_axis_tdata, output, C_M00_AXIS_TDATA_WIDTH bits, the signed scaled sample.
REQ-014 The block SHALL have port m00_axis_tstrb, output, C_M00_AXIS_TDATA_WIDTH/8 bits, the byte strobes.
REQ-015 The block SHALL have port overflow, output, 1 bit, a sticky drop flag.
REQ-016 The block SHALL have port drop_count, output, 16 bits, the count of dropped samples.

Function
REQ-017 Sample acceptance SHALL occur in a cycle with adc_valid=1, enable=1, and either buffer count < FIFO_DEPTH or a pop occurring in the same cycle.
REQ-018 Conversion SHALL invert adc_data[7] to form a signed 8-bit value, sign-extend it to C_M00_AXIS_TDATA_WIDTH, then arithmetic-left-shift it by shift as sampled in the accept cycle, with no saturation needed: a result of at most 23 significant bits always fits 32 bits.
REQ-019 Conversion examples SHALL hold with shift=0: 0x80 -> 0x00000000, 0xFF -> 0x0000007F, 0x00 -> 0xFFFFFF80.
REQ-020 Conversion examples SHALL hold with shift=4: 0x00 -> 0xFFFFF800.
REQ-021 The buffer SHALL be a first-word-fall-through FIFO of FIFO_DEPTH entries, each entry holding {tlast, tdata}.
REQ-022 A pop SHALL occur when m00_axis_tvalid=1 and m00_axis_tready=1.
REQ-023 Latency SHALL be fixed: a sample accepted in cycle N into an empty FIFO presents m00_axis_tvalid=1 with its data from cycle N+1.
REQ-024 m00_axis_tvalid SHALL equal (count != 0).
REQ-025 m00_axis_tdata and m00_axis_tlast SHALL be held stable while tvalid=1 and tready=0.
REQ-026 m00_axis_tstrb SHALL be constant all-ones.
REQ-027 A frame counter SHALL count 0..FRAME_LEN-1 on accepted samples only.
REQ-028 The sample accepted at count FRAME_LEN-1 SHALL be stored with tlast=1, after which the counter wraps to 0.
REQ-029 When FRAME_LEN=1, every sample SHALL carry tlast=1.
REQ-030 While enable=0, no samples SHALL be accepted and the frame counter SHALL be held at 0, so that re-enabling starts a new frame.
REQ-031 While enable=0, entries already buffered SHALL continue to drain normally.
REQ-032 Drop: a cycle with adc_valid=1, enable=1, count=FIFO_DEPTH and no pop SHALL discard the sample.
REQ-033 On a drop, overflow SHALL be set to 1 and held until reset.
REQ-034 On a drop, drop_count SHALL increment, saturating at 0xFFFF.
REQ-035 On a drop, the frame counter SHALL not advance.
REQ-036 A simultaneous push and pop SHALL leave count unchanged, including when count=FIFO_DEPTH and when count=1.
REQ-037 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-038 adc_valid while enable=0 SHALL be ignored and SHALL not count as a drop.

Reset
REQ-039 Assertion of m00_axis_aresetn=0 SHALL immediately, without waiting for a clock edge, clear the FIFO pointers and count, the frame counter, overflow and drop_count.
REQ-040 During and directly after reset, m00_axis_tvalid=0, m00_axis_tlast=0 and m00_axis_tdata=0.
REQ-041 Reset asserted mid-frame or mid-backpressure SHALL discard all buffered data.
REQ-042 After reset, the first accepted sample SHALL be frame index 0.
REQ-043 Release of reset SHALL be synchronous to m00_axis_aclk; the first acceptance may occur on the first edge after release.

Verification
REQ-044 Scenario "basic": FRAME_LEN=4, tready=1, shift=0, samples 0x80,0xFF,0x00,0x81 on consecutive cycles -> tdata 0x0,0x7F,0xFFFFFF80,0x1, tlast only on the 4th, each output one cycle after its input.
REQ-045 Scenario "gain": shift=15, sample 0x00 -> tdata 0xFFC00000; sample 0xFF -> tdata 0x003F8000.
REQ-046 Scenario "overflow": FIFO_DEPTH=8, tready=0, 10 consecutive strobes -> 8 buffered, overflow=1, drop_count=2; then tready=1 -> exactly the first 8 samples emerge in order, and the frame counter has advanced by 8.
REQ-047 Scenario "full-simultaneous": FIFO full, tready=1 and adc_valid=1 in the same cycle -> no drop, count stays 8, drop_count unchanged.
REQ-048 Scenario "enable": enable dropped after the 2nd sample of a frame and raised again later -> the next sample restarts at index 0, tlast lands FRAME_LEN accepted samples later, and strobes while disabled are not counted.
REQ-049 Scenario "reset": async reset pulse mid-frame with 5 entries buffered -> tvalid=0 before the next clock edge, drop_count=0, and the post-reset frame starts at index 0.
